pll_clock_sequencer: RTL and testbench
======================================

Name: pll_clock_sequencer

Overview:
- Power-up and recovery sequencer for the iCE40 clock path: SB_HFOSC output, then SB_PLL40_CORE, then the SPI IP clock domain.
- Holds the PLL in reset, waits for lock, qualifies lock stability, then releases a system reset to the SPI logic.
- Handles lock loss with bounded retries, then falls back to PLL bypass (reference clock passed straight through).
- Runs on the free-running oscillator clock, never on the PLL output.

Parameters:
- RST_CYCLES, 16: cycles pll_resetb is held low per attempt (must be >= 1).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before an attempt counts as failed.
- STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before release.
- MAX_RETRY, 3: failed attempts tolerated before BYPASS (must be >= 1).
- CNT_W, 16: width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clk, in, 1: oscillator clock (CLKHF).
- rst_n, in, 1: asynchronous active-low reset.
- pll_lock, in, 1: PLL LOCK, asynchronous to clk.
- sw_restart, in, 1: single-cycle pulse; restarts the sequence from PLL_RST with retry count cleared.
- pll_resetb, out, 1: drives PLL RESETB (active low).
- pll_bypass, out, 1: drives PLL BYPASS.
- sys_rst_n, out, 1: active-low reset to the downstream SPI logic.
- clk_ready, out, 1: high in RUN or BYPASS.
- lock_lost, out, 1: sticky flag, set on lock loss while in RUN; cleared by rst_n or sw_restart.
- retry_cnt, out, 2: failed attempts so far (saturates at 3).
- state_o, out, 3: encoded state (PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, BYPASS=4).

Behaviour:
- Reset values (rst_n low, asynchronous):
  - state PLL_RST, counter 0, retry_cnt 0.
  - pll_resetb 0, pll_bypass 0, sys_rst_n 0, clk_ready 0, lock_lost 0.
  - lock synchronizer flops 0.
- Lock sync: pll_lock passes through a 2-flop synchronizer giving lock_s. All decisions use lock_s, so there are 2 cycles of input latency.
- All outputs are registered. State changes take effect on outputs one cycle after the transition condition is seen.
- PLL_RST:
  - pll_resetb=0, sys_rst_n=0.
  - Counter counts 0..RST_CYCLES-1.
  - On the terminal count, go to WAIT_LOCK and clear the counter.
- WAIT_LOCK:
  - pll_resetb=1.
  - lock_s=1: go to STABLE, clear the counter.
  - Counter reaches LOCK_TIMEOUT-1 without lock: failed attempt.
- STABLE:
  - lock_s=0 at any cycle: go back to WAIT_LOCK, counter cleared. This is not a failed attempt.
  - STABLE_CYCLES consecutive lock_s=1 cycles: go to RUN.
  - The WAIT_LOCK timeout does not run while in STABLE.
- RUN:
  - sys_rst_n goes to 1 on the first cycle in RUN (deassertion is synchronous to clk). clk_ready=1.
  - lock_s=0: set lock_lost, sys_rst_n=0 on the next cycle, counts as a failed attempt.
- Failed attempt:
  - If retry_cnt+1 < MAX_RETRY: increment retry_cnt, go to PLL_RST.
  - Otherwise: increment retry_cnt (saturating), go to BYPASS.
- BYPASS:
  - pll_bypass=1, pll_resetb=0, sys_rst_n=1, clk_ready=1.
  - lock_s is ignored. Exit only via sw_restart or rst_n.
- sw_restart:
  - Taken in any state; has priority over every other transition in the same cycle.
  - Effect: go to PLL_RST, counter=0, retry_cnt=0, lock_lost=0, pll_bypass=0, sys_rst_n=0.
- Simultaneous events: lock drop on the same cycle as the STABLE terminal count goes to WAIT_LOCK, not RUN.
- Counter width: the counter never wraps; it is always cleared on a state change.
- rst_n mid-sequence: immediate return to the reset values; the sequence restarts from PLL_RST.

Test Plan:
- Nominal lock: release rst_n, raise pll_lock 10 cycles after pll_resetb rises, hold it.
  - pll_resetb low exactly 16 cycles.
  - state goes to STABLE 2 cycles after lock (sync latency).
  - sys_rst_n and clk_ready rise 256 cycles later; retry_cnt=0.
- Glitchy lock: lock high 100 cycles in STABLE, low 5, then high.
  - Returns to WAIT_LOCK, then STABLE restarts its 256-cycle count.
  - sys_rst_n stays 0 throughout; retry_cnt=0.
- No lock: pll_lock held 0.
  - Three timeouts of 4096 cycles, each followed by a 16-cycle PLL_RST.
  - Ends in BYPASS with pll_bypass=1, sys_rst_n=1, retry_cnt=3.
- Lock loss in RUN: drop pll_lock after RUN is reached.
  - lock_lost=1; sys_rst_n falls within 4 cycles of the drop; retry_cnt=1; state PLL_RST.
  - On relock, RUN is reached again with lock_lost still 1.
- sw_restart while in BYPASS, with lock_s=1 on the same cycle.
  - state PLL_RST next cycle; retry_cnt=0, lock_lost=0, pll_bypass=0, sys_rst_n=0.
- Async reset mid-STABLE: pulse rst_n low for 3 ns between clk edges.
  - All outputs return to their reset values immediately, without waiting for a clk edge.
  - After release, a full 16-cycle PLL_RST phase follows.

Source files
------------

// File: rtl/pll_clock_sequencer.sv
// Power-up / recovery sequencer for the HFOSC -> PLL40 -> SPI clock path.
// Runs on the free-running oscillator clock; all outputs are registered.
module pll_clock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       sw_restart,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       sys_rst_n,
  output logic       clk_ready,
  output logic       lock_lost,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
);

  localparam logic [2:0] PLL_RST   = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] BYPASS    = 3'd4;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             lock_meta_q, lock_s_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             fail;
  logic             pll_resetb_q, pll_bypass_q, sys_rst_n_q, clk_ready_q;

  // pll_lock is asynchronous to the oscillator clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    fail    = 1'b0;
    if (sw_restart) begin
      state_d = PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            fail = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE: begin
          // A lock drop wins over the terminal count and is not a failed attempt.
          if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (!lock_s_q) begin
            lost_d = 1'b1;
            fail   = 1'b1;
          end
        end
        BYPASS: begin
        end
        default: begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
      endcase

      if (fail) begin
        cnt_d = '0;
        if (retry_q != 2'd3) begin
          retry_d = retry_q + 2'd1;
        end
        if (({30'd0, retry_q} + 32'd1) < MAX_RETRY) begin
          state_d = PLL_RST;
        end else begin
          state_d = BYPASS;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
    end
  end

  // Outputs are decoded from the next state so they line up with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_resetb_q <= 1'b0;
      pll_bypass_q <= 1'b0;
      sys_rst_n_q  <= 1'b0;
      clk_ready_q  <= 1'b0;
    end else begin
      pll_resetb_q <= (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
      pll_bypass_q <= (state_d == BYPASS);
      sys_rst_n_q  <= (state_d == RUN) || (state_d == BYPASS);
      clk_ready_q  <= (state_d == RUN) || (state_d == BYPASS);
    end
  end

  assign pll_resetb = pll_resetb_q;
  assign pll_bypass = pll_bypass_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign clk_ready  = clk_ready_q;
  assign lock_lost  = lost_q;
  assign retry_cnt  = retry_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pll_clock_sequencer.sv
// Self-checking bench for pll_clock_sequencer: vector table, hand sequences,
// and randomized lock/restart traffic against a phase-duration reference model.
module tb_pll_clock_sequencer;

  localparam int unsigned RST_C  = 16;
  localparam int unsigned TO_C   = 4096;
  localparam int unsigned STB_C  = 256;
  localparam int unsigned MAXR_C = 3;

  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_BYP = 4;

  logic       clk = 1'b0;
  logic       rst_n, pll_lock, sw_restart;
  logic       pll_resetb, pll_bypass, sys_rst_n, clk_ready, lock_lost;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, cycles spent in it, and a 2-deep lock delay line.
  int m_phase, m_el, m_retry;
  bit m_lost;
  bit sync_q[$];

  typedef struct {
    logic        sw;
    logic        lock;
    int unsigned n;
    logic [9:0]  exp;
  } vec_t;
  vec_t tbl[$];

  pll_clock_sequencer #(
    .RST_CYCLES(RST_C),
    .LOCK_TIMEOUT(TO_C),
    .STABLE_CYCLES(STB_C),
    .MAX_RETRY(MAXR_C),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_lock(pll_lock),
    .sw_restart(sw_restart),
    .pll_resetb(pll_resetb),
    .pll_bypass(pll_bypass),
    .sys_rst_n(sys_rst_n),
    .clk_ready(clk_ready),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ev(input int st, input bit rb, input bit byp, input bit srn,
                                    input bit rdy, input bit lost, input int rc);
    return {3'(st), rb, byp, srn, rdy, lost, 2'(rc)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {state_o, pll_resetb, pll_bypass, sys_rst_n, clk_ready, lock_lost, retry_cnt};
  endfunction

  function automatic logic [9:0] model_vec();
    bit in_pll = (m_phase == P_WAIT) || (m_phase == P_STB) || (m_phase == P_RUN);
    bit up     = (m_phase == P_RUN) || (m_phase == P_BYP);
    return ev(m_phase, in_pll, m_phase == P_BYP, up, up, m_lost, m_retry);
  endfunction

  task automatic check_vec(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = dut_vec();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: actual st/rb/byp/srn/rdy/lost/rc=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RST;
    m_el    = 0;
    m_retry = 0;
    m_lost  = 0;
    sync_q  = '{1'b0, 1'b0};
  endtask

  task automatic model_fail();
    m_el = 0;
    if (m_retry + 1 < int'(MAXR_C)) begin
      m_retry++;
      m_phase = P_RST;
    end else begin
      if (m_retry < 3) m_retry++;
      m_phase = P_BYP;
    end
  endtask

  task automatic model_step();
    bit lock_s;
    if (!rst_n) return;
    lock_s = sync_q[0];
    void'(sync_q.pop_front());
    sync_q.push_back(pll_lock);
    if (sw_restart) begin
      m_phase = P_RST; m_el = 0; m_retry = 0; m_lost = 0;
      return;
    end
    case (m_phase)
      P_RST:  if (m_el + 1 == int'(RST_C)) begin m_phase = P_WAIT; m_el = 0; end else m_el++;
      P_WAIT: if (lock_s) begin m_phase = P_STB; m_el = 0; end
              else if (m_el + 1 == int'(TO_C)) model_fail();
              else m_el++;
      P_STB:  if (!lock_s) begin m_phase = P_WAIT; m_el = 0; end
              else if (m_el + 1 == int'(STB_C)) begin m_phase = P_RUN; m_el = 0; end
              else m_el++;
      P_RUN:  if (!lock_s) begin m_lost = 1; model_fail(); end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_vec("model", model_vec());
  endtask

  task automatic add(input logic sw, input logic lock, input int unsigned n, input logic [9:0] exp);
    vec_t v;
    v.sw = sw; v.lock = lock; v.n = n; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    int unsigned hold;

    // nominal lock
    add(0, 0, 15,   ev(P_RST, 0,0,0,0,0,0));
    add(0, 0, 1,    ev(P_WAIT,1,0,0,0,0,0));
    add(0, 0, 10,   ev(P_WAIT,1,0,0,0,0,0));
    add(0, 1, 2,    ev(P_WAIT,1,0,0,0,0,0));
    add(0, 1, 1,    ev(P_STB, 1,0,0,0,0,0));
    add(0, 1, 255,  ev(P_STB, 1,0,0,0,0,0));
    add(0, 1, 1,    ev(P_RUN, 1,0,1,1,0,0));
    // lock loss in RUN, then relock
    add(0, 0, 2,    ev(P_RUN, 1,0,1,1,0,0));
    add(0, 0, 1,    ev(P_RST, 0,0,0,0,1,1));
    add(0, 1, 16,   ev(P_WAIT,1,0,0,0,1,1));
    add(0, 1, 1,    ev(P_STB, 1,0,0,0,1,1));
    add(0, 1, 256,  ev(P_RUN, 1,0,1,1,1,1));
    add(1, 1, 1,    ev(P_RST, 0,0,0,0,0,0));
    // no lock: three timeouts then BYPASS
    add(0, 0, 16,   ev(P_WAIT,1,0,0,0,0,0));
    add(0, 0, 4095, ev(P_WAIT,1,0,0,0,0,0));
    add(0, 0, 1,    ev(P_RST, 0,0,0,0,0,1));
    add(0, 0, 15,   ev(P_RST, 0,0,0,0,0,1));
    add(0, 0, 1,    ev(P_WAIT,1,0,0,0,0,1));
    add(0, 0, 4095, ev(P_WAIT,1,0,0,0,0,1));
    add(0, 0, 1,    ev(P_RST, 0,0,0,0,0,2));
    add(0, 0, 16,   ev(P_WAIT,1,0,0,0,0,2));
    add(0, 0, 4095, ev(P_WAIT,1,0,0,0,0,2));
    add(0, 0, 1,    ev(P_BYP, 0,1,1,1,0,3));
    add(0, 1, 5,    ev(P_BYP, 0,1,1,1,0,3));
    add(1, 1, 1,    ev(P_RST, 0,0,0,0,0,0));
    // glitchy lock in STABLE
    add(0, 1, 16,   ev(P_WAIT,1,0,0,0,0,0));
    add(0, 1, 1,    ev(P_STB, 1,0,0,0,0,0));
    add(0, 1, 99,   ev(P_STB, 1,0,0,0,0,0));
    add(0, 0, 2,    ev(P_STB, 1,0,0,0,0,0));
    add(0, 0, 1,    ev(P_WAIT,1,0,0,0,0,0));
    add(0, 0, 2,    ev(P_WAIT,1,0,0,0,0,0));
    add(0, 1, 2,    ev(P_WAIT,1,0,0,0,0,0));
    add(0, 1, 1,    ev(P_STB, 1,0,0,0,0,0));
    add(0, 1, 255,  ev(P_STB, 1,0,0,0,0,0));
    add(0, 1, 1,    ev(P_RUN, 1,0,1,1,0,0));

    rst_n = 1'b0; pll_lock = 1'b0; sw_restart = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_vec("reset", ev(P_RST,0,0,0,0,0,0));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      pll_lock   = tbl[i].lock;
      sw_restart = tbl[i].sw;
      repeat (tbl[i].n) tick();
      sw_restart = 1'b0;
      check_vec($sformatf("vec%0d", i), tbl[i].exp);
    end

    // async reset pulse while in STABLE
    sw_restart = 1'b1; pll_lock = 1'b1;
    tick();
    sw_restart = 1'b0;
    repeat (17 + 50) tick();
    check_vec("pre_async_stable", ev(P_STB,1,0,0,0,0,0));
    #1 rst_n = 1'b0;
    #1 check_vec("async_reset", ev(P_RST,0,0,0,0,0,0));
    model_reset();
    #2 rst_n = 1'b1;
    repeat (15) tick();
    check_vec("post_reset_rst", ev(P_RST,0,0,0,0,0,0));
    tick();
    check_vec("post_reset_wait", ev(P_WAIT,1,0,0,0,0,0));

    // randomized lock behaviour with occasional restarts
    hold = 0;
    for (int c = 0; c < 9000; c++) begin
      if (hold == 0) begin
        pll_lock = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 9) == 0) ? 4500 : $urandom_range(1, 300);
      end
      hold--;
      sw_restart = ($urandom_range(0, 799) == 0);
      tick();
      sw_restart = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
